// File: rtl/ex_pkg.sv
// ex_pkg: opcodes, FSM states and default widths shared by the execute stage.
// Latency/backpressure: n/a (types and constants only).
package ex_pkg;
   localparam int OP_W       = 4;
   localparam int XLEN_DEF   = 32;
   localparam int REG_AW_DEF = 5;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_SLT = 4'd5,
      OP_SLL = 4'd6,
      OP_SRL = 4'd7,
      OP_BEQ = 4'd8,
      OP_BNE = 4'd9,
      OP_MUL = 4'd10
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;
endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: shift-add unsigned multiplier, one multiplier bit per cycle, low XLEN bits kept.
// Latency: done_o is high during the XLEN-th busy cycle; no backpressure, abort_i drops work at once.
module ex_mul_iter
   import ex_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);
   localparam int CW = $clog2(XLEN);

   logic [XLEN-1:0] acc_q, mcand_q, mplier_q, step;
   logic [CW-1:0]   cnt_q;
   logic            busy_q;

   // The final partial product is folded in combinationally so the result is ready on the last step.
   assign step     = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign busy_o   = busy_q;
   assign done_o   = busy_q && (cnt_q == CW'(XLEN-1));
   assign result_o = step;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (abort_i) begin
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start_i) begin
         acc_q    <= '0;
         mcand_q  <= a_i;
         mplier_q <= b_i;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         acc_q    <= step;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
         if (done_o) busy_q <= 1'b0;
      end
   end
endmodule

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: ALU, branch resolve and target into an EX/MEM output register; iterative MUL if EX_MUL_EN.
// Latency 1 cycle (MUL: XLEN); in_ready drops combinationally on a stalled full output or busy MUL.
module ex_stage_pipe
   import ex_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   op,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   input  logic [XLEN-1:0]   imm,
   input  logic [XLEN-1:0]   pc_plus4,
   input  logic [REG_AW-1:0] rt_idx,
   input  logic [REG_AW-1:0] rd_idx,
   input  logic              reg_dst,
   input  logic              alu_src,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_result,
   output logic [REG_AW-1:0] out_wreg,
   output logic              out_br_taken,
   output logic [XLEN-1:0]   out_br_target,
   output logic              out_illegal
);
   localparam int SHW = $clog2(XLEN);

   state_e            state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   out_result_q, out_result_d;
   logic [REG_AW-1:0] out_wreg_q, out_wreg_d;
   logic              out_taken_q, out_taken_d;
   logic [XLEN-1:0]   out_target_q, out_target_d;
   logic              out_illegal_q, out_illegal_d;

   op_e               opc;
   logic [XLEN-1:0]   opb, alu_res, br_target;
   logic [REG_AW-1:0] wreg;
   logic              br_taken, illegal, accept, is_mul;

   assign opc       = op_e'(op);
   assign opb       = alu_src ? imm : b;
   assign wreg      = reg_dst ? rd_idx : rt_idx;
   assign br_target = pc_plus4 + (imm << 2);
   assign in_ready  = !rst && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready && !flush;

   always_comb begin
      alu_res  = '0;
      br_taken = 1'b0;
      illegal  = 1'b0;
      case (opc)
         OP_ADD: alu_res = a + opb;
         OP_SUB: alu_res = a - opb;
         OP_AND: alu_res = a & opb;
         OP_OR:  alu_res = a | opb;
         OP_XOR: alu_res = a ^ opb;
         OP_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(opb))};
         OP_SLL: alu_res = a << opb[SHW-1:0];
         OP_SRL: alu_res = a >> opb[SHW-1:0];
         OP_BEQ: br_taken = (a == b);
         OP_BNE: br_taken = (a != b);
`ifdef EX_MUL_EN
         OP_MUL: alu_res = '0;
`endif
         default: illegal = 1'b1;
      endcase
   end

`ifdef EX_MUL_EN
   logic              mul_start, mul_busy, mul_done;
   logic [XLEN-1:0]   mul_res, pend_target_q;
   logic [REG_AW-1:0] pend_wreg_q;

   assign is_mul    = (opc == OP_MUL);
   assign mul_start = accept && is_mul;

   ex_mul_iter #(.XLEN(XLEN)) u_mul (
      .clk      (clk),
      .rst      (rst),
      .start_i  (mul_start),
      .abort_i  (flush),
      .a_i      (a),
      .b_i      (opb),
      .busy_o   (mul_busy),
      .done_o   (mul_done),
      .result_o (mul_res)
   );

   // Destination and target are captured at accept; the multiplier only carries the operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_target_q <= '0;
         pend_wreg_q   <= '0;
      end else if (mul_start) begin
         pend_target_q <= br_target;
         pend_wreg_q   <= wreg;
      end
   end
`else
   assign is_mul = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      out_valid_d   = out_valid_q;
      out_result_d  = out_result_q;
      out_wreg_d    = out_wreg_q;
      out_taken_d   = out_taken_q;
      out_target_d  = out_target_q;
      out_illegal_d = out_illegal_q;
      if (flush) begin
         state_d     = ST_IDLE;
         out_valid_d = 1'b0;
      end else begin
         if (out_ready) out_valid_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     state_d = ST_BUSY;
                  end else begin
                     out_valid_d   = 1'b1;
                     out_result_d  = alu_res;
                     out_wreg_d    = wreg;
                     out_taken_d   = br_taken;
                     out_target_d  = br_target;
                     out_illegal_d = illegal;
                  end
               end
            end
`ifdef EX_MUL_EN
            ST_BUSY: begin
               if (mul_done) begin
                  state_d       = ST_IDLE;
                  out_valid_d   = 1'b1;
                  out_result_d  = mul_res;
                  out_wreg_d    = pend_wreg_q;
                  out_taken_d   = 1'b0;
                  out_target_d  = pend_target_q;
                  out_illegal_d = 1'b0;
               end else if (!mul_busy) begin
                  state_d = ST_IDLE;
               end
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         out_valid_q   <= 1'b0;
         out_result_q  <= '0;
         out_wreg_q    <= '0;
         out_taken_q   <= 1'b0;
         out_target_q  <= '0;
         out_illegal_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         out_valid_q   <= out_valid_d;
         out_result_q  <= out_result_d;
         out_wreg_q    <= out_wreg_d;
         out_taken_q   <= out_taken_d;
         out_target_q  <= out_target_d;
         out_illegal_q <= out_illegal_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_result    = out_result_q;
   assign out_wreg      = out_wreg_q;
   assign out_br_taken  = out_taken_q;
   assign out_br_target = out_target_q;
   assign out_illegal   = out_illegal_q;
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Bench for ex_stage_pipe: directed cases plus random traffic against a timed scoreboard model.
module tb_ex_stage_pipe;
`ifdef EX_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif
   localparam int XL = 32;

   logic        clk, rst, in_valid, in_ready, reg_dst, alu_src, flush;
   logic        out_valid, out_ready, out_br_taken, out_illegal;
   logic [3:0]  op;
   logic [31:0] a, b, imm, pc_plus4, out_result, out_br_target;
   logic [4:0]  rt_idx, rd_idx, out_wreg;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [31:0] result;
      logic [4:0]  wreg;
      logic        taken;
      logic [31:0] target;
      logic        illegal;
      int          avail;
   } exp_t;

   exp_t sb[$];

   ex_stage_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .imm(imm), .pc_plus4(pc_plus4), .rt_idx(rt_idx), .rd_idx(rd_idx),
      .reg_dst(reg_dst), .alu_src(alu_src), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_wreg(out_wreg),
      .out_br_taken(out_br_taken), .out_br_target(out_br_target), .out_illegal(out_illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t ref_model(input logic [3:0] o, input logic [31:0] ia, ib, iimm, ipc,
                                      input logic [4:0] irt, ird, input logic rdst, asrc, input int now);
      exp_t r;
      logic [31:0] opb;
      opb       = asrc ? iimm : ib;
      r.result  = 0;
      r.taken   = 1'b0;
      r.illegal = 1'b0;
      r.wreg    = rdst ? ird : irt;
      r.target  = ipc + iimm * 4;
      r.avail   = now + 1;
      case (o)
         0: r.result = ia + opb;
         1: r.result = ia - opb;
         2: r.result = ia & opb;
         3: r.result = ia | opb;
         4: r.result = ia ^ opb;
         5: r.result = ($signed(ia) < $signed(opb)) ? 32'd1 : 32'd0;
         6: r.result = ia << (opb % XL);
         7: r.result = ia >> (opb % XL);
         8: r.taken  = (ia == ib);
         9: r.taken  = (ia != ib);
         10: if (MUL_EN) begin
                r.result = ia * opb;
                r.avail  = now + XL;
             end else r.illegal = 1'b1;
         default: r.illegal = 1'b1;
      endcase
      return r;
   endfunction

   // Timed scoreboard: an entry becomes visible at its avail cycle and leaves when consumed.
   always @(negedge clk) begin
      bit exp_vld, exp_rdy;
      cyc++;
      if (rst) begin
         sb.delete();
         check("rst_in_ready", in_ready, 0);
         check("rst_out_valid", out_valid, 0);
      end else begin
         exp_vld = (sb.size() != 0) && (cyc >= sb[0].avail);
         exp_rdy = !((sb.size() != 0) && !exp_vld) && (!exp_vld || out_ready);
         check("out_valid", out_valid, exp_vld);
         check("in_ready", in_ready, exp_rdy);
         if (exp_vld && out_valid) begin
            check("sb_result", out_result, sb[0].result);
            check("sb_wreg", out_wreg, sb[0].wreg);
            check("sb_taken", out_br_taken, sb[0].taken);
            check("sb_target", out_br_target, sb[0].target);
            check("sb_illegal", out_illegal, sb[0].illegal);
         end
         if (flush) sb.delete();
         else begin
            if (exp_vld && out_ready) void'(sb.pop_front());
            if (in_valid && exp_rdy)
               sb.push_back(ref_model(op, a, b, imm, pc_plus4, rt_idx, rd_idx, reg_dst, alu_src, cyc));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] o, input logic [31:0] ia, ib, iimm, ipc,
                        input logic [4:0] ird, input logic asrc);
      in_valid = 1'b1; op = o; a = ia; b = ib; imm = iimm; pc_plus4 = ipc;
      rt_idx = 5'd3; rd_idx = ird; reg_dst = 1'b1; alu_src = asrc;
   endtask

   initial begin
      int n, seen;
      rst = 1'b1; in_valid = 0; op = 0; a = 0; b = 0; imm = 0; pc_plus4 = 0;
      rt_idx = 0; rd_idx = 0; reg_dst = 0; alu_src = 0; flush = 0; out_ready = 1;
      repeat (2) step();
      check("reset_in_ready", in_ready, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_result", out_result, 0);
      check("reset_out_target", out_br_target, 0);
      check("reset_out_wreg", out_wreg, 0);
      rst = 1'b0;
      #1;
      check("first_in_ready", in_ready, 1);

      drive(0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0, 5'd7, 1'b0);
      step();
      check("add_valid", out_valid, 1);
      check("add_result", out_result, 0);
      check("add_wreg", out_wreg, 7);

      drive(8, 32'd5, 32'd5, 32'hFFFF_FFFE, 32'h100, 5'd1, 1'b0);
      step();
      check("beq_taken", out_br_taken, 1);
      check("beq_target", out_br_target, 32'hF8);
      check("beq_result", out_result, 0);
      drive(9, 32'd5, 32'd5, 32'hFFFF_FFFE, 32'h100, 5'd1, 1'b0);
      step();
      check("bne_taken", out_br_taken, 0);

      drive(5, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h0, 5'd2, 1'b1);
      step();
      check("slt_result", out_result, 1);
      drive(7, 32'h8000_0000, 32'd31, 32'd0, 32'h0, 5'd2, 1'b0);
      step();
      check("srl_result", out_result, 1);
      drive(13, 32'd9, 32'd9, 32'd0, 32'h0, 5'd2, 1'b0);
      step();
      check("op13_illegal", out_illegal, 1);
      check("op13_result", out_result, 0);
      drive(10, 32'd7, 32'd6, 32'd0, 32'h0, 5'd4, 1'b0);
      step();
      in_valid = 0;
`ifdef EX_MUL_EN
      check("mul_busy_in_ready", in_ready, 0);
      check("mul_busy_out_valid", out_valid, 0);
      a = 32'd9; b = 32'd9;
      n = 0;
      while (!out_valid && n < 100) begin step(); n++; end
      check("mul_latency", n, 32);
      check("mul_result", out_result, 42);
      check("mul_wreg", out_wreg, 4);

      drive(10, 32'd3, 32'd5, 32'd0, 32'h0, 5'd4, 1'b0);
      step();
      in_valid = 0;
      repeat (9) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_out_valid", out_valid, 0);
      check("flush_in_ready", in_ready, 1);
      seen = 0;
      repeat (40) begin step(); if (out_valid) seen++; end
      check("flush_no_output", seen, 0);

      drive(10, 32'd11, 32'd13, 32'd0, 32'h0, 5'd4, 1'b0);
      step();
      in_valid = 0;
      repeat (5) step();
      rst = 1'b1;
      #1;
      check("rst_mid_mul_valid", out_valid, 0);
      check("rst_mid_mul_result", out_result, 0);
      check("rst_mid_mul_in_ready", in_ready, 0);
      step();
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", in_ready, 1);
`else
      check("mul_off_illegal", out_illegal, 1);
      check("mul_off_valid", out_valid, 1);
      check("mul_off_result", out_result, 0);
`endif

      // Back-pressure: three ADDs with the consumer stalled for four cycles.
      in_valid = 0; out_ready = 1;
      step();
      out_ready = 0;
      drive(0, 32'd1, 32'd1, 32'd0, 32'h0, 5'd1, 1'b0);
      step();
      drive(0, 32'd2, 32'd2, 32'd0, 32'h0, 5'd2, 1'b0);
      for (int k = 0; k < 4; k++) begin
         check("bp_in_ready", in_ready, 0);
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_result", out_result, 2);
         check("bp_hold_wreg", out_wreg, 1);
         step();
      end
      out_ready = 1;
      #1;
      check("bp_release_in_ready", in_ready, 1);
      step();
      check("bp_second_result", out_result, 4);
      drive(0, 32'd3, 32'd3, 32'd0, 32'h0, 5'd3, 1'b0);
      step();
      check("bp_third_result", out_result, 6);
      check("bp_third_wreg", out_wreg, 3);
      in_valid = 0;
      step();
      check("bp_drained", out_valid, 0);

      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         op        = 4'($urandom_range(0, 15));
         a         = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
         b         = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
         imm       = ($urandom_range(0, 1) == 0) ? 32'($signed($urandom_range(0, 15)) - 8) : $urandom;
         pc_plus4  = $urandom;
         rt_idx    = 5'($urandom);
         rd_idx    = 5'($urandom);
         reg_dst   = 1'($urandom);
         alu_src   = 1'($urandom);
         flush     = ($urandom_range(0, 40) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      in_valid = 0; flush = 0; out_ready = 1;
      n = 0;
      while (sb.size() != 0 && n < 200) begin step(); n++; end
      check("drain_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised execute stage of the pipelined CPU, sitting between the ID/EX and EX/MEM boundaries. It selects ALU operands and the destination register, executes the ALU operation, resolves BEQ/BNE, and computes the branch target. Results are held in an internal EX/MEM output register with a valid/ready handshake on both sides. An optional iterative multiplier adds a multi-cycle MUL operation.

## Interface
- XLEN, 32, datapath width; must be a power of two and at least 8
- REG_AW, 5, register-index width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream holds a valid operation
- in_ready  out  1  stage accepts the operation this cycle
- op  in  4  operation code (see Operation)
- a, b  in  XLEN  register operands rs, rt
- imm  in  XLEN  sign-extended immediate
- pc_plus4  in  XLEN  PC of the instruction plus 4
- rt_idx, rd_idx  in  REG_AW  candidate destination registers
- reg_dst  in  1  0 selects rt_idx, 1 selects rd_idx
- alu_src  in  1  0 sets operand B to b, 1 sets it to imm
- flush  in  1  synchronous kill of in-flight and held work
- out_valid  out  1  output register holds a result
- out_ready  in  1  downstream consumes the result
- out_result  out  XLEN  ALU or MUL result; 0 for branches
- out_wreg  out  REG_AW  selected destination index
- out_br_taken  out  1  branch resolved taken
- out_br_target  out  XLEN  pc_plus4 + (imm << 2), modulo 2^XLEN
- out_illegal  out  1  op was unsupported; out_result is 0

## Operation
- Operand B is `opb = alu_src ? imm : b`. All arithmetic is modulo 2^XLEN.
- Opcodes:
  - 0 ADD: a+opb
  - 1 SUB: a−opb
  - 2 AND, 3 OR, 4 XOR: bitwise
  - 5 SLT: signed a<opb, giving 1 or 0
  - 6 SLL, 7 SRL: logical shift of a by opb[log2(XLEN)-1:0]
  - 8 BEQ: taken if a==b
  - 9 BNE: taken if a!=b
  - 10 MUL: low XLEN bits of a*opb, unsigned
  - 11–15: illegal
- Branch ops always compare a against b, ignoring alu_src. For non-branch ops, out_br_taken is 0.
- out_br_target is computed for every op.
- Every op defines every output. No output holds a stale value from an earlier op.
- FSM states and transitions:
  - IDLE: an accepted non-MUL op loads the output register directly. An accepted MUL goes to BUSY with count = 0.
  - BUSY: shift-add one bit per cycle. When count = XLEN−1, load the output register and go to IDLE.
- `in_ready = !rst && state==IDLE && (!out_valid || out_ready)`.
- An accepted op captures all of its inputs. Later changes on the input ports do not affect it.
- Output register rules:
  - It loads when a result completes.
  - out_valid clears on out_ready when no new result is loading in the same cycle.
  - A simultaneous consume and load keeps out_valid at 1 with the new data.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
- Flush rules:
  - Clears out_valid and sends the FSM to IDLE.
  - An in_valid handshake in the same cycle as flush is discarded.
  - Flush has priority over out_ready, over completion, and over acceptance.

## Timing
- Reset values: out_valid=0, all out_* data=0, state=IDLE, count=0. in_ready=0 while rst is high.
- On the first cycle after rst deasserts, in_ready=1.
- Non-MUL: accepted at edge N, out_valid=1 after edge N. Throughput is one op per cycle when out_ready=1.
- MUL: accepted at edge N, out_valid=1 after edge N+XLEN. in_ready=0 during BUSY.
- Reset asserted mid-BUSY: immediate abort. No partial result is ever presented.
- Back-pressure: if out_ready=0 with out_valid=1, in_ready drops in the same cycle (combinational). No op is lost.

## Configuration
- EX_MUL_EN defined:
  - op 10 is the iterative MUL described above.
  - Instantiates ex_mul_iter and the BUSY state.
- EX_MUL_EN undefined:
  - No multiplier and no BUSY state; the FSM is IDLE-only.
  - op 10 is treated as illegal: single-cycle, out_result=0, out_illegal=1.

## Structure
- Package ex_pkg holds:
  - the opcode enum (OP_ADD … OP_MUL) and OP_W=4
  - the FSM state enum
  - the default XLEN and REG_AW values
- Sub-module ex_mul_iter holds the shift-add multiplier:
  - start/busy/done handshake
  - internal accumulator, operand shift registers and counter
  - exists only when EX_MUL_EN is defined
- The ALU is combinational inside ex_stage_pipe. The output register and FSM are in the same module.

## Test plan
- ADD with a=0xFFFFFFFF, b=1, alu_src=0, reg_dst=1, rd_idx=7, out_ready=1 → one cycle later: out_result=0, out_wreg=7, out_valid=1.
- BEQ with a=b=5, imm=0xFFFFFFFE, pc_plus4=0x100 → out_br_taken=1, out_br_target=0xF8, out_result=0. BNE with the same operands → out_br_taken=0.
- SLT with a=0xFFFFFFFF, alu_src=1, imm=1 → out_result=1. SRL with a=0x80000000, b=31 → out_result=1.
- Back-pressure: three ADDs with out_ready held 0 for 4 cycles → first result held stable, in_ready=0, all three results emerge in order once out_ready=1.
- MUL (EX_MUL_EN) with a=7, b=6 → out_valid rises exactly 32 cycles after accept with out_result=42. A second MUL flushed at cycle 10 → no output, in_ready=1 on the next cycle.
- Reset asserted mid-MUL → outputs zero immediately. Op 13 → out_illegal=1, out_result=0. Without EX_MUL_EN, op 10 → out_illegal=1 after one cycle.
